// File: rtl/router_pkg.sv
// Shared types and defaults for the router egress lane arbiter.
package router_pkg;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DRAIN
   } arb_state_t;

   localparam int DEF_DATA  = 64;
   localparam int DEF_LANES = 4;
   localparam int DEF_BURST = 4;

   // Burst counter must be able to hold BURST itself.
   function automatic int cnt_w(input int burst);
      return $clog2(burst + 1);
   endfunction

endpackage

// File: rtl/lane_arbiter_if.sv
// Lane-side and egress-side signals of the lane arbiter.
interface lane_arbiter_if
   import router_pkg::*;
#(
   parameter int DATA  = DEF_DATA,
   parameter int LANES = DEF_LANES
);

   logic [LANES-1:0]           REQ;
   logic [LANES-1:0][DATA-1:0] IN;
   logic [LANES-1:0]           RD;
   logic [DATA-1:0]            OUT;
   logic                       WR;
   logic                       dst_BUSY;
   logic [LANES-1:0]           GNT;
   logic                       ACTIVE;

   modport master (
      input  REQ, IN, dst_BUSY,
      output RD, OUT, WR, GNT, ACTIVE
   );

   modport slave (
      output REQ, IN, dst_BUSY,
      input  RD, OUT, WR, GNT, ACTIVE
   );

endinterface

// File: rtl/rr_pick.sv
// First requester at or after ptr, wrapping modulo LANES.
module rr_pick
   import router_pkg::*;
#(
   parameter  int LANES = DEF_LANES,
   localparam int IW    = $clog2(LANES)
) (
   input  logic [LANES-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic             found,
   output logic [IW-1:0]    idx
);

   int j;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < LANES; k++) begin
         j = int'(ptr) + k;
         if (j >= LANES) j = j - LANES;
         if (!found && req[IW'(j)]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/lane_arbiter.sv
// Round-robin burst arbiter from LANES input FIFOs onto one egress lane.
module lane_arbiter
   import router_pkg::*;
#(
   parameter int DATA  = DEF_DATA,
   parameter int LANES = DEF_LANES,
   parameter int BURST = DEF_BURST
) (
   input logic            clK,
   input logic            rsT_n,
   lane_arbiter_if.master bus
);

   localparam int IW = $clog2(LANES);
   localparam int CW = cnt_w(BURST);
   localparam logic [CW-1:0] CMAX = CW'(BURST);
   localparam logic [IW-1:0] LAST = IW'(LANES - 1);

   arb_state_t       state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    gsel;
   logic [IW-1:0]    win;
   logic [IW-1:0]    nxt;
   logic [CW-1:0]    cnt;
   logic [LANES-1:0] gnt;
   logic [LANES-1:0] rd;
   logic [DATA-1:0]  out;
   logic             found;
   logic             pop;
   logic             dry;
   logic             done;
   logic             rd_q;
   logic             wr;

   rr_pick #(.LANES(LANES)) u_pick (
      .req   (bus.REQ),
      .ptr   (ptr),
      .found (found),
      .idx   (win)
   );

   // Busy only stalls pops; a dry lane ends the grant once egress is free.
   assign pop  = (state == XFER) && bus.REQ[gsel]
               && !bus.dst_BUSY && (cnt < CMAX);
   assign dry  = !bus.REQ[gsel] && !bus.dst_BUSY;
   assign done = (cnt == CMAX) || dry;
   assign nxt  = (gsel == LAST) ? '0 : gsel + IW'(1);

   always_comb begin
      rd       = '0;
      rd[gsel] = pop;
   end

   always_ff @(posedge clK or negedge rsT_n) begin
      if (!rsT_n) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
         gsel  <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  gsel  <= win;
                  gnt   <= LANES'(1) << win;
                  cnt   <= '0;
                  state <= XFER;
               end
            end
            XFER: begin
               if (pop) cnt <= cnt + CW'(1);
               if (done) begin
                  ptr   <= nxt;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               gnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Two-stage pipe: lane data arrives a cycle after RD, then registers out.
   always_ff @(posedge clK or negedge rsT_n) begin
      if (!rsT_n) begin
         rd_q <= 1'b0;
         wr   <= 1'b0;
         out  <= '0;
      end else begin
         rd_q <= |rd;
         wr   <= rd_q;
         if (rd_q) out <= bus.IN[gsel];
      end
   end

   assign bus.RD     = rd;
   assign bus.GNT    = gnt;
   assign bus.WR     = wr;
   assign bus.OUT    = out;
   assign bus.ACTIVE = (state != IDLE);

endmodule

// File: tb/tb_lane_arbiter.sv
// Randomised and directed bench for lane_arbiter against a lane/scoreboard model.
module tb_lane_arbiter;

   localparam int DATA  = 64;
   localparam int LANES = 4;
   localparam int BURST = 4;

   typedef logic [LANES-1:0] lane_t;
   typedef logic [DATA-1:0]  word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   lane_arbiter_if #(.DATA(DATA), .LANES(LANES)) bus ();

   lane_arbiter #(
      .DATA  (DATA),
      .LANES (LANES),
      .BURST (BURST)
   ) dut (
      .clK   (clk),
      .rsT_n (rst_n),
      .bus   (bus)
   );

   word_t lq[LANES][$];
   word_t exp_q[$];
   word_t log_o[$];
   int    log_g[$];
   int    log_n[$];
   lane_t pend;
   lane_t prev_req;
   lane_t prev_gnt;
   lane_t last_rd;
   logic  rdh1;
   logic  rdh2;
   logic  busy_v;
   logic  rnd;
   int    mptr;
   int    cur;
   int    burst_n;
   int    wctr;
   int    n_chk;
   int    n_fail;

   task automatic check(input string tag, input word_t got, input word_t exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_req();
      for (int i = 0; i < LANES; i++) bus.REQ[i] = (lq[i].size() != 0);
   endtask

   task automatic load(input int lane, input int n, input word_t base);
      for (int i = 0; i < n; i++) lq[lane].push_back(base + word_t'(i));
      drive_req();
   endtask

   task automatic clear_logs();
      log_o.delete();
      log_g.delete();
      log_n.delete();
   endtask

   task automatic reset_model();
      exp_q.delete();
      pend     = '0;
      prev_gnt = '0;
      last_rd  = '0;
      rdh1     = 1'b0;
      rdh2     = 1'b0;
      mptr     = 0;
      cur      = 0;
      burst_n  = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      busy_v = 1'b0;
      bus.dst_BUSY = 1'b0;
      bus.IN = '0;
      for (int i = 0; i < LANES; i++) lq[i].delete();
      drive_req();
      reset_model();
      clear_logs();
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd", bus.RD, 0);
      check("rst_gnt", bus.GNT, 0);
      check("rst_wr", bus.WR, 0);
      check("rst_out", bus.OUT, 0);
      check("rst_active", bus.ACTIVE, 0);
      rst_n = 1'b1;
   endtask

   task automatic step();
      lane_t rd;
      lane_t gnt;
      int w;
      int best;
      int d;
      @(posedge clk);
      #1;
      prev_req = bus.REQ;
      for (int i = 0; i < LANES; i++)
         if (pend[i]) bus.IN[i] = lq[i].pop_front();
      pend = '0;
      if (rnd)
         for (int i = 0; i < LANES; i++)
            if (!prev_gnt[i] && $urandom_range(0, 7) == 0) begin
               lq[i].push_back({word_t'(i), 56'(wctr)});
               wctr++;
            end
      drive_req();
      bus.dst_BUSY = busy_v;
      #1;
      rd  = bus.RD;
      gnt = bus.GNT;
      check("rd_req", rd & ~bus.REQ, 0);
      check("rd_gnt", rd & ~gnt, 0);
      if (busy_v) check("rd_busy", rd, 0);
      check("gnt_1hot", $onehot0(gnt), 1);
      check("active", bus.ACTIVE, gnt != 0);
      check("wr_lat", bus.WR, rdh2);
      if (bus.WR) begin
         check("out_q", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            check("out", bus.OUT, exp_q.pop_front());
            log_o.push_back(bus.OUT);
         end
      end
      if (prev_gnt == 0 && gnt != 0) begin
         w = -1;
         best = LANES;
         for (int i = 0; i < LANES; i++)
            if (prev_req[i]) begin
               d = (i - mptr + LANES) % LANES;
               if (d < best) begin
                  best = d;
                  w = i;
               end
            end
         check("grant", gnt, (w < 0) ? lane_t'(0) : lane_t'(1) << w);
         cur = (w < 0) ? 0 : w;
         burst_n = 0;
         log_g.push_back(w);
      end else if (prev_gnt != 0) begin
         check("gnt_hold", (gnt == 0) || (gnt == prev_gnt), 1);
      end
      if (rd != 0) burst_n++;
      if (prev_gnt != 0 && gnt == 0) begin
         check("burst_max", burst_n >= 1 && burst_n <= BURST, 1);
         check("burst_end", burst_n == BURST || lq[cur].size() == 0, 1);
         log_n.push_back(burst_n);
         mptr = (cur + 1) % LANES;
      end
      for (int i = 0; i < LANES; i++)
         if (rd[i]) begin
            exp_q.push_back(lq[i][0]);
            pend[i] = 1'b1;
         end
      last_rd  = rd;
      rdh2     = rdh1;
      rdh1     = |rd;
      prev_gnt = gnt;
   endtask

   initial begin
      int wrc;
      logic seen;
      n_chk = 0;
      n_fail = 0;
      wctr = 0;
      rnd = 1'b0;
      bus.REQ = '0;
      bus.IN = '0;
      bus.dst_BUSY = 1'b0;

      // single requester, 6 words over two grants
      do_reset();
      load(1, 6, 64'hA0);
      repeat (30) step();
      check("t1_nout", log_o.size(), 6);
      if (log_o.size() == 6)
         for (int i = 0; i < 6; i++) check("t1_out", log_o[i], 64'hA0 + word_t'(i));
      check("t1_ngnt", log_g.size(), 2);
      if (log_g.size() == 2 && log_n.size() == 2) begin
         check("t1_g0", log_g[0], 1);
         check("t1_g1", log_g[1], 1);
         check("t1_n0", log_n[0], 4);
         check("t1_n1", log_n[1], 2);
      end

      // all lanes busy: strict rotation, full bursts
      do_reset();
      for (int i = 0; i < LANES; i++) load(i, 8, word_t'(i) << 8);
      repeat (90) step();
      check("t2_ngnt", log_g.size(), 8);
      check("t2_nout", log_o.size(), 32);
      if (log_g.size() == 8 && log_n.size() == 8)
         for (int i = 0; i < 8; i++) begin
            check("t2_order", log_g[i], i % LANES);
            check("t2_burst", log_n[i], BURST);
         end

      // lane runs dry after 2 words; pointer moves past it
      do_reset();
      load(2, 2, 64'hB0);
      repeat (12) step();
      check("t3_ngnt", log_g.size(), 1);
      if (log_g.size() == 1 && log_n.size() == 1) begin
         check("t3_g0", log_g[0], 2);
         check("t3_n0", log_n[0], 2);
      end
      for (int i = 0; i < LANES; i++) load(i, 1, 64'hD0 + word_t'(i));
      repeat (40) step();
      if (log_g.size() >= 3) begin
         check("t3_g1", log_g[1], 3);
         check("t3_g2", log_g[2], 0);
      end else check("t3_ngnt2", log_g.size(), 5);

      // backpressure for 5 cycles mid-burst
      do_reset();
      load(0, 4, 64'hC0);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step();
         seen = (last_rd != 0);
      end
      check("t4_start", seen, 1);
      busy_v = 1'b1;
      wrc = 0;
      repeat (5) begin
         step();
         wrc += int'(bus.WR);
      end
      check("t4_wr_stall", wrc <= 2, 1);
      busy_v = 1'b0;
      repeat (20) step();
      check("t4_nout", log_o.size(), 4);
      if (log_o.size() == 4)
         for (int i = 0; i < 4; i++) check("t4_out", log_o[i], 64'hC0 + word_t'(i));

      // asynchronous reset in the middle of a burst
      do_reset();
      load(0, 6, 64'hE0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         step();
         seen = bus.WR;
      end
      check("t5_start", seen, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_wr", bus.WR, 0);
      check("t5_rd", bus.RD, 0);
      check("t5_gnt", bus.GNT, 0);
      check("t5_active", bus.ACTIVE, 0);
      for (int i = 0; i < LANES; i++) lq[i].delete();
      reset_model();
      clear_logs();
      load(3, 2, 64'hF0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (15) step();
      check("t5_ngnt", log_g.size(), 1);
      if (log_g.size() == 1) check("t5_g0", log_g[0], 3);
      check("t5_nout", log_o.size(), 2);

      // random traffic and backpressure
      do_reset();
      rnd = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         busy_v = ($urandom_range(0, 3) == 0);
         step();
      end
      rnd = 1'b0;
      busy_v = 1'b0;
      repeat (200) step();
      check("drain_q", exp_q.size(), 0);
      check("drain_idle", bus.ACTIVE, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
